alu_seq: RTL and testbench

- Parametrised, handshaked successor to the datapath's combinational 64-bit ALU.
- Accepts one operation per transaction over a valid/ready input channel and returns a registered result and zero flag over a valid/ready output channel.
- Logic ops, add/sub, shifts and set-less-than complete in one cycle.
- Multiply is an iterative shift-add sequence, which lets the multicycle datapath issue MUL without a combinational multiplier.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_mul_seq.sv | 65 ++++++
 rtl/alu_seq.sv | 159 +++++++++++++++
 tb/tb_alu_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------+
// | alu_pkg: opcode constants and FSM state type shared by alu_seq.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// +--------------------------------------------------------------------+
// | alu_mul_seq: iterative shift-add multiplier, MUL_STEP bits/cycle.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_mul_seq #(
    parameter int WIDTH    = 64,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] multiplicand_i,
    input  logic [WIDTH-1:0] multiplier_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int N_STEPS = WIDTH / MUL_STEP;
    localparam int CNT_W   = $clog2(N_STEPS + 1);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] partial;

    // Partial product of the multiplicand and the low MUL_STEP multiplier bits.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
    end

    // Final step: the product is presented combinationally so the top can
    // register it on the same edge the counter retires its last step.
    assign product_o = acc_q + partial;
    assign done_o    = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            mcand_q  <= multiplicand_i;
            mplier_q <= multiplier_i;
            acc_q    <= '0;
            cnt_q    <= CNT_W'(N_STEPS);
        end else if (cnt_q != '0) begin
            mcand_q  <= mcand_q << MUL_STEP;
            mplier_q <= mplier_q >> MUL_STEP;
            acc_q    <= product_o;
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// +--------------------------------------------------------------------+
// | alu_seq: handshaked ALU, single-cycle ops plus iterative MUL.      |
// | Optional overflow output: define ALU_SEQ_OVERFLOW_EN.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef ALU_SEQ_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu;
    logic             w_accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = (result_q == '0);

    assign w_sum  = data1 + data2;
    assign w_diff = data1 - data2;

    always_comb begin
        w_alu = '0;
        unique case (op)
            OP_AND:  w_alu = data1 & data2;
            OP_OR:   w_alu = data1 | data2;
            OP_ADD:  w_alu = w_sum;
            OP_XOR:  w_alu = data1 ^ data2;
            OP_SLL:  w_alu = data1 << data2[SHW-1:0];
            OP_SRL:  w_alu = data1 >> data2[SHW-1:0];
            OP_SUB:  w_alu = w_diff;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
            default: w_alu = '0;
        endcase
    end

`ifdef ALU_SEQ_OVERFLOW_EN
    logic ovf_q;
    logic ovf_d;
    logic w_ovf;

    always_comb begin
        w_ovf = 1'b0;
        if (op == OP_ADD) begin
            w_ovf = (data1[WIDTH-1] == data2[WIDTH-1]) && (w_sum[WIDTH-1] != data1[WIDTH-1]);
        end else if (op == OP_SUB) begin
            w_ovf = (data1[WIDTH-1] != data2[WIDTH-1]) && (w_diff[WIDTH-1] != data1[WIDTH-1]);
        end
    end

    assign overflow = ovf_q;
`endif

    // An accept can only occur in IDLE or DONE, so it overrides the
    // state-specific transition (DONE + accept is the back-to-back case).
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        mul_start = 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
        ovf_d     = ovf_q;
`endif
        unique case (state_q)
            ST_IDLE: ;
            ST_MUL: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    result_d = mul_product;
`ifdef ALU_SEQ_OVERFLOW_EN
                    ovf_d    = 1'b0;
`endif
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_accept) begin
            if (op == OP_MUL) begin
                state_d   = ST_MUL;
                mul_start = 1'b1;
            end else begin
                state_d  = ST_DONE;
                result_d = w_alu;
`ifdef ALU_SEQ_OVERFLOW_EN
                ovf_d    = w_ovf;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
`ifdef ALU_SEQ_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
`ifdef ALU_SEQ_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    alu_mul_seq #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (mul_start),
        .multiplicand_i (data1),
        .multiplier_i   (data2),
        .done_o         (mul_done),
        .product_o      (mul_product)
    );

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// +--------------------------------------------------------------------+
// | tb_alu_seq: directed scoreboard bench for alu_seq (WIDTH=64).      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alu_seq;

    localparam int W = 64;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data1;
    logic [W-1:0] data2;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
`ifdef ALU_SEQ_OVERFLOW_EN
    logic         overflow;
`endif

    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    exp_t pend;

    alu_seq #(.WIDTH(W), .MUL_STEP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data1     (data1),
        .data2     (data2),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
`ifdef ALU_SEQ_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: consume/compare a handshaked result, record an accepted op,
    // then advance to 1 time unit after the rising edge.
    task automatic cyc();
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_result", result, e.res);
                chk("sb_zero", {63'd0, zero}, {63'd0, (e.res == '0)});
`ifdef ALU_SEQ_OVERFLOW_EN
                chk("sb_overflow", {63'd0, overflow}, {63'd0, e.ovf});
`endif
            end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1 && rst_n === 1'b1) begin
            sb.push_back(pend);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic v);
        in_valid = 1'b1;
        op       = o;
        data1    = a;
        data2    = b;
        pend.res = r;
        pend.ovf = v;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n;
        int ready_hi;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'h0;
        data1     = '0;
        data2     = '0;
        pend.res  = '0;
        pend.ovf  = 1'b0;

        repeat (3) cyc();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_zero", {63'd0, zero}, 64'd1);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;
        cyc();

        // ADD then SUB, one-cycle latency
        out_ready = 1'b1;
        drive(4'b0010, 64'd5, 64'd7, 64'd12, 1'b0);
        cyc();
        in_valid = 1'b0;
        chk("add_latency", {63'd0, out_valid}, 64'd1);
        chk("add_zero_flag", {63'd0, zero}, 64'd0);
        cyc();
        chk("add_drop_valid", {63'd0, out_valid}, 64'd0);
        drive(4'b0110, 64'd5, 64'd5, 64'd0, 1'b0);
        cyc();
        in_valid = 1'b0;
        chk("sub_zero_flag", {63'd0, zero}, 64'd1);
        cyc();

        // MUL 3 * all-ones; operands/in_valid ignored while busy
        out_ready = 1'b0;
        drive(4'b1000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        cyc();
        drive(4'b0000, 64'hDEAD, 64'hBEEF, 64'h0, 1'b0);
        ready_hi = 0;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            if (in_ready !== 1'b0) ready_hi++;
            data1 = data1 + 64'd1;
            cyc();
            n++;
        end
        chk("mul_busy_cycles", 64'(n), 64'd64);
        chk("mul_in_ready_low", 64'(ready_hi), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();

        // Back-to-back single-cycle ops, one result per cycle
        drive(4'b0000, 64'hF0, 64'h3C, 64'h30, 1'b0);
        cyc();
        drive(4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0);
        cyc();
        chk("b2b_valid_1", {63'd0, out_valid}, 64'd1);
        drive(4'b0100, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0);
        cyc();
        chk("b2b_valid_2", {63'd0, out_valid}, 64'd1);
        drive(4'b0101, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0);
        cyc();
        chk("b2b_valid_3", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b0;
        cyc();

        // Backpressure after ADD
        out_ready = 1'b0;
        drive(4'b0010, 64'd100, 64'd23, 64'd123, 1'b0);
        cyc();
        drive(4'b0001, 64'h55, 64'hAA, 64'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_result", result, 64'd123);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("bp_release", {63'd0, out_valid}, 64'd0);

        // SLT and an undefined opcode
        drive(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0);
        cyc();
        drive(4'b0111, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        cyc();
        drive(4'b1111, 64'h1234, 64'h5678, 64'd0, 1'b0);
        cyc();
        in_valid = 1'b0;
        cyc();

        // Signed-overflow corner cases
        drive(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1);
        cyc();
        drive(4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        cyc();
        in_valid = 1'b0;
        cyc();

        // Reset 10 cycles into a MUL aborts it
        drive(4'b1000, 64'd9, 64'd9, 64'd81, 1'b0);
        cyc();
        in_valid = 1'b0;
        repeat (9) cyc();
        rst_n = 1'b0;
        cyc();
        sb.delete();
        rst_n = 1'b1;
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        drive(4'b1000, 64'd6, 64'd7, 64'd42, 1'b0);
        cyc();
        in_valid = 1'b0;
        wait_valid(n);
        chk("mul2_busy_cycles", 64'(n), 64'd64);
        cyc();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
